// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM states,
// error-reason codes, default geometry and the address check.
package dmem_responder_pkg;

  localparam int DMEM_DEPTH_DEFAULT   = 256;
  localparam int DMEM_LATENCY_DEFAULT = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  typedef logic [1:0] err_reason_t;

  localparam err_reason_t ERR_NONE     = 2'b00;
  localparam err_reason_t ERR_MISALIGN = 2'b01;
  localparam err_reason_t ERR_RANGE    = 2'b10;

  // Classify a byte address against a byte limit (DEPTH*4).
  function automatic err_reason_t addr_check(input logic [31:0] addr,
                                             input logic [31:0] limit);
    if (addr[1:0] != 2'b00) return ERR_MISALIGN;
    if (addr >= limit) return ERR_RANGE;
    return ERR_NONE;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with registered read data.
// Contents are never cleared; they are undefined until written.
module dmem_array #(
  parameter int DEPTH = 256,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          we,
  input  logic          re,
  input  logic [IW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Write on we; read data only updates on re so it holds between reads.
  always_ff @(posedge clock) begin
    if (we) mem[idx] <= wdata;
    if (re) rdata <= mem[idx];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one CPU load/store at a time, answers it
// LATENCY cycles after acceptance and holds the response until taken.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. req_ready is 1 only in IDLE; resp_valid is 1 only in RESP and the
// response (d_datain, resp_err) is held stable until resp_ready is seen.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH   = DMEM_DEPTH_DEFAULT,
  parameter int LATENCY = DMEM_LATENCY_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] d_dataout,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] d_datain,
  output logic        resp_err,
  input  logic        resp_ready,
  output logic [15:0] served_count,
  output dmem_state_t state_dbg
);

  localparam int          IW         = $clog2(DEPTH);
  localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH * 4);
  localparam logic [3:0]  WAIT_LOAD  = 4'(LATENCY - 1);
  localparam logic        DIRECT     = (LATENCY == 1);

  dmem_state_t   state, state_next;
  logic [3:0]    wait_cnt, wait_cnt_next;
  logic          fire;

  logic          lat_write;
  logic [IW-1:0] lat_idx;
  logic [31:0]   lat_data;
  err_reason_t   lat_err;

  err_reason_t   req_err;
  logic          op_write;
  logic [IW-1:0] op_idx;
  logic [31:0]   op_data;
  err_reason_t   op_err;

  logic          accept, handshake;
  logic          ram_we, ram_re;
  logic [31:0]   ram_rdata;
  logic [15:0]   served_q;

  assign req_err   = addr_check(req_addr, ADDR_LIMIT);
  assign accept    = req_valid && (state == IDLE);
  assign handshake = (state == RESP) && resp_ready;

  // Next-state logic; fire marks the edge on which resp_valid rises.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    fire          = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (DIRECT) begin
            state_next = RESP;
            fire       = 1'b1;
          end else begin
            state_next    = WAIT;
            wait_cnt_next = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (wait_cnt <= 4'd1) begin
          state_next = RESP;
          fire       = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Memory operands: straight from the request when firing out of IDLE
  // (LATENCY=1), otherwise from the copy latched at acceptance.
  always_comb begin
    if (state == IDLE) begin
      op_write = req_write;
      op_idx   = req_addr[IW+1:2];
      op_data  = d_dataout;
      op_err   = req_err;
    end else begin
      op_write = lat_write;
      op_idx   = lat_idx;
      op_data  = lat_data;
      op_err   = lat_err;
    end
  end

  // A reset on the firing edge aborts the access, so a pending store is lost.
  assign ram_we = fire && op_write && (op_err == ERR_NONE) && !reset;
  assign ram_re = fire && !op_write && (op_err == ERR_NONE) && !reset;

  dmem_array #(.DEPTH(DEPTH), .IW(IW)) u_array (
    .clock (clock),
    .we    (ram_we),
    .re    (ram_re),
    .idx   (op_idx),
    .wdata (op_data),
    .rdata (ram_rdata)
  );

  // State register, request latch and handshake counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      lat_write <= 1'b0;
      lat_idx   <= '0;
      lat_data  <= '0;
      lat_err   <= ERR_NONE;
      served_q  <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      if (accept) begin
        lat_write <= req_write;
        lat_idx   <= req_addr[IW+1:2];
        lat_data  <= d_dataout;
        lat_err   <= req_err;
      end
      if (handshake) served_q <= served_q + 16'd1;
    end
  end

  assign req_ready    = (state == IDLE);
  assign resp_valid   = (state == RESP);
  assign resp_err     = resp_valid && (lat_err != ERR_NONE);
  assign d_datain     = (resp_valid && !lat_write && (lat_err == ERR_NONE)) ? ram_rdata : 32'd0;
  assign served_count = served_q;
  assign state_dbg    = state;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=2 instance for the main scenarios and
// a LATENCY=1 instance for the direct path and counter wrap.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam int DEPTH = 256;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset;

  logic        req_valid, req_write, resp_ready;
  logic [31:0] req_addr, d_dataout;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] d_datain;
  logic [15:0] served_count;
  dmem_state_t state_dbg;

  logic        x_req_valid, x_req_write, x_resp_ready;
  logic [31:0] x_req_addr, x_d_dataout;
  logic        x_req_ready, x_resp_valid, x_resp_err;
  logic [31:0] x_d_datain;
  logic [15:0] x_served_count;
  dmem_state_t x_state_dbg;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .d_dataout(d_dataout), .req_ready(req_ready),
    .resp_valid(resp_valid), .d_datain(d_datain), .resp_err(resp_err),
    .resp_ready(resp_ready), .served_count(served_count), .state_dbg(state_dbg)
  );

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut1 (
    .clock(clock), .reset(reset), .req_valid(x_req_valid), .req_write(x_req_write),
    .req_addr(x_req_addr), .d_dataout(x_d_dataout), .req_ready(x_req_ready),
    .resp_valid(x_resp_valid), .d_datain(x_d_datain), .resp_err(x_resp_err),
    .resp_ready(x_resp_ready), .served_count(x_served_count), .state_dbg(x_state_dbg)
  );

  // ---------------- scoreboard / reference model ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_served = 16'd0;
  logic [31:0] model_mem [int];
  logic [31:0] exp_q [$];

  function automatic logic addr_is_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= 32'(DEPTH * 4));
  endfunction

  function automatic void model_store(input logic [31:0] a, input logic [31:0] d);
    if (!addr_is_err(a)) model_mem[int'(a >> 2)] = d;
  endfunction

  // ---------------- driver ----------------
  // Called at a negedge with the responder idle; returns at a negedge after
  // the response handshake. lat counts cycles from accept to resp_valid.
  task automatic drive_txn(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                           output logic [31:0] rdata, output logic rerr, output int lat);
    req_valid = 1'b1; req_write = wr; req_addr = addr; d_dataout = data; resp_ready = 1'b0;
    @(posedge clock); @(negedge clock);
    req_valid = 1'b0; req_write = 1'($urandom_range(0, 1)); req_addr = $urandom; d_dataout = $urandom;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge clock); @(negedge clock);
      lat++;
    end
    rdata = d_datain; rerr = resp_err;
    resp_ready = 1'b1;
    @(posedge clock); @(negedge clock);
    resp_ready = 1'b0;
    exp_served++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    n_checks++; if (req_ready !== 1'b1) begin n_errors++; $display("FAIL rst_req_ready: got %b expected 1", req_ready); end
    n_checks++; if (resp_valid !== 1'b0) begin n_errors++; $display("FAIL rst_resp_valid: got %b expected 0", resp_valid); end
    n_checks++; if (d_datain !== 32'd0) begin n_errors++; $display("FAIL rst_d_datain: got %h expected 0", d_datain); end
    n_checks++; if (resp_err !== 1'b0) begin n_errors++; $display("FAIL rst_resp_err: got %b expected 0", resp_err); end
    n_checks++; if (served_count !== 16'd0) begin n_errors++; $display("FAIL rst_served: got %0d expected 0", served_count); end
    n_checks++; if (state_dbg !== IDLE) begin n_errors++; $display("FAIL rst_state: got %0d expected IDLE", state_dbg); end
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic re; int lat;
    drive_txn(1'b1, 32'h10, 32'hDEADBEEF, rd, re, lat); model_store(32'h10, 32'hDEADBEEF);
    n_checks++; if (lat !== 2) begin n_errors++; $display("FAIL sl_store_lat: got %0d expected 2", lat); end
    n_checks++; if (re !== 1'b0) begin n_errors++; $display("FAIL sl_store_err: got %b expected 0", re); end
    n_checks++; if (rd !== 32'd0) begin n_errors++; $display("FAIL sl_store_data: got %h expected 0", rd); end
    drive_txn(1'b0, 32'h10, 32'h0, rd, re, lat);
    n_checks++; if (lat !== 2) begin n_errors++; $display("FAIL sl_load_lat: got %0d expected 2", lat); end
    n_checks++; if (re !== 1'b0) begin n_errors++; $display("FAIL sl_load_err: got %b expected 0", re); end
    n_checks++; if (rd !== 32'hDEADBEEF) begin n_errors++; $display("FAIL sl_load_data: got %h expected deadbeef", rd); end
    n_checks++; if (served_count !== 16'd2) begin n_errors++; $display("FAIL sl_served: got %0d expected 2", served_count); end
  endtask

  task automatic test_misaligned();
    logic [31:0] rd; logic re; int lat;
    drive_txn(1'b0, 32'h13, 32'h0, rd, re, lat);
    n_checks++; if (re !== 1'b1) begin n_errors++; $display("FAIL mis_load_err: got %b expected 1", re); end
    n_checks++; if (rd !== 32'd0) begin n_errors++; $display("FAIL mis_load_data: got %h expected 0", rd); end
    drive_txn(1'b1, 32'h11, 32'h55555555, rd, re, lat);
    n_checks++; if (re !== 1'b1) begin n_errors++; $display("FAIL mis_store_err: got %b expected 1", re); end
    drive_txn(1'b0, 32'h10, 32'h0, rd, re, lat);
    n_checks++; if (rd !== model_mem[4]) begin n_errors++; $display("FAIL mis_mem_intact: got %h expected %h", rd, model_mem[4]); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; logic re; int lat;
    drive_txn(1'b1, 32'h0, 32'h11111111, rd, re, lat); model_store(32'h0, 32'h11111111);
    drive_txn(1'b1, 32'h400, 32'hCAFEF00D, rd, re, lat);
    n_checks++; if (re !== 1'b1) begin n_errors++; $display("FAIL oor_store_err: got %b expected 1", re); end
    drive_txn(1'b0, 32'h0, 32'h0, rd, re, lat);
    n_checks++; if (rd !== model_mem[0]) begin n_errors++; $display("FAIL oor_word0: got %h expected %h", rd, model_mem[0]); end
    drive_txn(1'b0, 32'h10, 32'h0, rd, re, lat);
    n_checks++; if (rd !== model_mem[4]) begin n_errors++; $display("FAIL oor_word4: got %h expected %h", rd, model_mem[4]); end
    drive_txn(1'b0, 32'h400, 32'h0, rd, re, lat);
    n_checks++; if (re !== 1'b1 || rd !== 32'd0) begin n_errors++; $display("FAIL oor_load: got err=%b data=%h expected err=1 data=0", re, rd); end
  endtask

  task automatic test_hold();
    logic [31:0] rd; logic re; int lat; int cyc;
    drive_txn(1'b1, 32'h30, 32'h0BADF00D, rd, re, lat); model_store(32'h30, 32'h0BADF00D);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; resp_ready = 1'b0;
    @(posedge clock); @(negedge clock);
    req_valid = 1'b0;
    cyc = 0;
    while (!resp_valid && cyc < 20) begin @(posedge clock); @(negedge clock); cyc++; end
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (resp_valid !== 1'b1) begin n_errors++; $display("FAIL hold_valid[%0d]: got %b expected 1", i, resp_valid); end
      n_checks++; if (d_datain !== model_mem[4]) begin n_errors++; $display("FAIL hold_data[%0d]: got %h expected %h", i, d_datain, model_mem[4]); end
      n_checks++; if (resp_err !== 1'b0) begin n_errors++; $display("FAIL hold_err[%0d]: got %b expected 0", i, resp_err); end
      n_checks++; if (req_ready !== 1'b0) begin n_errors++; $display("FAIL hold_req_ready[%0d]: got %b expected 0", i, req_ready); end
      req_valid = (i % 2 == 0); req_write = 1'b1; req_addr = 32'h30; d_dataout = 32'hFFFFFFFF;
      @(posedge clock); @(negedge clock);
    end
    req_valid = 1'b0;
    n_checks++; if (resp_valid !== 1'b1) begin n_errors++; $display("FAIL hold_valid_end: got %b expected 1", resp_valid); end
    resp_ready = 1'b1;
    @(posedge clock); @(negedge clock);
    resp_ready = 1'b0; exp_served++;
    n_checks++; if (req_ready !== 1'b1) begin n_errors++; $display("FAIL hold_ready_after: got %b expected 1", req_ready); end
    n_checks++; if (resp_valid !== 1'b0 || d_datain !== 32'd0) begin n_errors++; $display("FAIL hold_idle_outputs: got valid=%b data=%h expected 0/0", resp_valid, d_datain); end
    n_checks++; if (served_count !== exp_served) begin n_errors++; $display("FAIL hold_served: got %0d expected %0d", served_count, exp_served); end
    drive_txn(1'b0, 32'h30, 32'h0, rd, re, lat);
    n_checks++; if (rd !== 32'h0BADF00D) begin n_errors++; $display("FAIL hold_ignored_req: got %h expected 0badf00d", rd); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd; logic re; int lat;
    drive_txn(1'b1, 32'h20, 32'hA5A5A5A5, rd, re, lat); model_store(32'h20, 32'hA5A5A5A5);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; d_dataout = 32'h12345678;
    @(posedge clock); @(negedge clock);
    req_valid = 1'b0; reset = 1'b1;
    @(posedge clock); @(negedge clock);
    reset = 1'b0; exp_served = 16'd0;
    n_checks++; if (served_count !== 16'd0) begin n_errors++; $display("FAIL abort_served: got %0d expected 0", served_count); end
    n_checks++; if (req_ready !== 1'b1) begin n_errors++; $display("FAIL abort_ready: got %b expected 1", req_ready); end
    @(posedge clock); @(negedge clock);
    n_checks++; if (resp_valid !== 1'b0) begin n_errors++; $display("FAIL abort_no_resp: got %b expected 0", resp_valid); end
    drive_txn(1'b0, 32'h20, 32'h0, rd, re, lat);
    n_checks++; if (rd === 32'h12345678) begin n_errors++; $display("FAIL abort_store_dropped: got %h expected not 12345678", rd); end
    n_checks++; if (rd !== model_mem[8]) begin n_errors++; $display("FAIL abort_old_word: got %h expected %h", rd, model_mem[8]); end
  endtask

  task automatic test_random();
    logic [31:0] rd, a, d, e; logic re, we; int lat, kind;
    for (int w = 64; w < 80; w++) begin
      d = $urandom;
      drive_txn(1'b1, 32'(w * 4), d, rd, re, lat); model_store(32'(w * 4), d);
    end
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 9);
      a = 32'h100 + 32'($urandom_range(0, 15) * 4);
      if (kind == 0) a = a + 32'($urandom_range(1, 3));
      else if (kind == 1) a = 32'h400 + 32'($urandom_range(0, 4000) * 4);
      we = 1'($urandom_range(0, 1)); d = $urandom;
      exp_q.push_back((we || addr_is_err(a)) ? 32'd0 : model_mem[int'(a >> 2)]);
      drive_txn(we, a, d, rd, re, lat);
      if (we) model_store(a, d);
      e = exp_q.pop_front();
      n_checks++; if (rd !== e || re !== addr_is_err(a) || lat !== 2) begin
        n_errors++;
        $display("FAIL rand[%0d] we=%b addr=%h: got data=%h err=%b lat=%0d expected data=%h err=%b lat=2", i, we, a, rd, re, lat, e, addr_is_err(a));
      end
    end
    n_checks++; if (served_count !== exp_served) begin n_errors++; $display("FAIL rand_served: got %0d expected %0d", served_count, exp_served); end
  endtask

  task automatic test_lat1_wrap();
    int bad_lat = 0, bad_data = 0, w;
    logic [31:0] wdata [8];
    logic [31:0] d;
    x_resp_ready = 1'b1;
    n_checks++; if (x_served_count !== 16'd0) begin n_errors++; $display("FAIL wrap_start: got %0d expected 0", x_served_count); end
    for (int k = 0; k < 65536; k++) begin
      w = (k / 2) % 8;
      x_req_valid = 1'b1; x_req_write = (k % 2 == 0); x_req_addr = 32'(w * 4);
      d = $urandom; x_d_dataout = d;
      if (k % 2 == 0) wdata[w] = d;
      @(posedge clock); @(negedge clock);
      x_req_valid = 1'b0; x_req_addr = $urandom; x_d_dataout = $urandom;
      if (x_resp_valid !== 1'b1) bad_lat++;
      else if (x_d_datain !== ((k % 2 == 1) ? wdata[w] : 32'd0)) bad_data++;
      @(posedge clock); @(negedge clock);
      if (k == 65534) begin
        n_checks++; if (x_served_count !== 16'hFFFF) begin n_errors++; $display("FAIL wrap_ffff: got %h expected ffff", x_served_count); end
      end
    end
    n_checks++; if (x_served_count !== 16'h0000) begin n_errors++; $display("FAIL wrap_zero: got %h expected 0000", x_served_count); end
    n_checks++; if (bad_lat !== 0) begin n_errors++; $display("FAIL lat1_latency: got %0d late responses expected 0", bad_lat); end
    n_checks++; if (bad_data !== 0) begin n_errors++; $display("FAIL lat1_data: got %0d bad responses expected 0", bad_data); end
    n_checks++; if (x_req_ready !== 1'b1) begin n_errors++; $display("FAIL lat1_ready: got %b expected 1", x_req_ready); end
  endtask

  // ---------------- sequence ----------------
  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0; d_dataout = 32'd0; resp_ready = 1'b0;
    x_req_valid = 1'b0; x_req_write = 1'b0; x_req_addr = 32'd0; x_d_dataout = 32'd0; x_resp_ready = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    test_reset();
    test_store_load();
    test_misaligned();
    test_out_of_range();
    test_hold();
    test_reset_abort();
    test_random();
    test_lat1_wrap();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Watchdog: the whole run is bounded in time.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
